// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART receiver and transmitter.
//   - default bit timing for 115200 baud on a 25 MHz clock
//   - receiver FSM state encoding
//   - bit positions of the status flags in the 16-bit status/data word
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 217;
  localparam int HALF_BIT_DEF     = 108;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int BUSY_EMPTY = 15;
  localparam int FRAME_ERR  = 14;

endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer for an asynchronous pad input.
// Both flops reset to 1 so an idle-high line is not seen as a falling
// edge while the synchronizer fills.
//   clk   in  system clock
//   reset in  synchronous, active-high reset
//   i_d   in  asynchronous input
//   o_q   out synchronized output
module uart_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART 8N1 receiver with a one-byte buffer.
//   clk   in  system clock
//   reset in  synchronous, active-high reset
//   clear in  one-cycle pulse, marks the buffer empty
//   RX    in  asynchronous serial input, idle high
//   out   out {empty, frame_err, 6'b0, byte}
// Optional feature macro: UART_RX_FRAME_CHECK_EN
//   defined   : a low stop bit discards the byte and sets sticky out[14]
//   undefined : stop bit ignored, out[14] is constant 0
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_IDLE  | line idle, waiting for rxs low
// ST_START | timing to start-bit mid-point, reject false starts
// ST_DATA  | sampling 8 data bits LSB first at bit mid-points
// ST_STOP  | waiting for stop-bit mid-point, then commit
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int HALF_BIT     = HALF_BIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        RX,
  output logic [15:0] out
);

  localparam logic [15:0] LP_BIT_END  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] LP_HALF_END = 16'(HALF_BIT - 1);

  logic        w_rxs;
  logic        w_ferr;
  logic [1:0]  r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shreg;
  logic [7:0]  r_data;
  logic        r_empty;

  uart_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (RX),
    .o_q   (w_rxs)
  );

`ifdef UART_RX_FRAME_CHECK_EN
  logic r_ferr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ferr <= 1'b0;
    end else if (r_state == ST_STOP && r_cnt == LP_BIT_END && !w_rxs) begin
      r_ferr <= 1'b1;
    end else if (clear) begin
      r_ferr <= 1'b0;
    end
  end

  assign w_ferr = r_ferr;
`else
  assign w_ferr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shreg <= '0;
      r_data  <= '0;
      r_empty <= 1'b1;
    end else begin
      if (clear) begin
        r_empty <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (!w_rxs) begin
            r_state <= ST_START;
            r_cnt   <= '0;
          end
        end
        ST_START: begin
          if (r_cnt == LP_HALF_END) begin
            r_cnt <= '0;
            if (w_rxs) begin
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_DATA;
              r_idx   <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (r_cnt == LP_BIT_END) begin
            // Right shift: the LSB-first bit stream lands in natural order.
            r_shreg <= {w_rxs, r_shreg[7:1]};
            r_cnt   <= '0;
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
              r_state <= ST_STOP;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (r_cnt == LP_BIT_END) begin
            // Back to IDLE at the stop-bit mid-point so an immediately
            // following start bit is caught. Commit overrides clear.
            r_state <= ST_IDLE;
            r_cnt   <= '0;
`ifdef UART_RX_FRAME_CHECK_EN
            if (w_rxs) begin
              r_data  <= r_shreg;
              r_empty <= 1'b0;
            end
`else
            r_data  <= r_shreg;
            r_empty <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    out             = '0;
    out[BUSY_EMPTY] = r_empty;
    out[FRAME_ERR]  = w_ferr;
    out[7:0]        = r_data;
  end

endmodule
